seq_addsub_chunked: RTL and testbench

- Parametrised multi-cycle adder/subtractor, the successor to the fixed 16-bit ripple adder.
- Processes CHUNK bits per clock, LSB chunk first, carrying between chunks in a register.
- Adds subtract mode, signed overflow detection and a start/busy/done handshake.
- Used as a shared arithmetic unit where area matters more than single-cycle latency.

---
 rtl/seq_addsub_chunked.sv | 95 +++++++++
 tb/tb_seq_addsub_chunked.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub_chunked.sv
// seq_addsub_chunked: multi-cycle add/subtract processing CHUNK bits per clock, LSB chunk first
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   start - request, accepted only while idle
//   op    - 0 = a+b+cin, 1 = a-b-cin (cin is borrow-in)
//   cin   - carry-in / borrow-in
//   a, b  - operands, captured when start is accepted
//   busy  - operation in progress
//   done  - one-cycle pulse when sum/cout/ovf update
//   sum   - result modulo 2^WIDTH
//   cout  - add: carry-out; sub: 1 = no borrow
//   ovf   - two's-complement signed overflow
module seq_addsub_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nxt;
    logic [IW-1:0] idx;
    logic carry, load, step, last, chunk_ovf;
    logic [WIDTH-1:0] opa, opb, shadow;
    logic [CHUNK:0] chunk_sum;
    logic [WIDTH+CHUNK-1:0] shifted;

    // Operand registers shift right each step, so the active chunk is always the low CHUNK bits.
    assign chunk_sum = {1'b0, opa[CHUNK-1:0]} + {1'b0, opb[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    // Result chunks enter at the top of the shadow register; after NCH steps it is fully ordered.
    assign shifted = {chunk_sum[CHUNK-1:0], shadow};
    // Same-sign operands giving a different-sign MSB is equivalent to carry-in XOR carry-out of the MSB.
    assign chunk_ovf = ~(opa[CHUNK-1] ^ opb[CHUNK-1]) & (opa[CHUNK-1] ^ chunk_sum[CHUNK-1]);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    always_comb
        state_nxt = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);

    always_comb begin
        busy = state == RUN;
        load = state == IDLE && start;
        step = state == RUN;
        last = step && idx == LAST;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx    <= '0;
            carry  <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            shadow <= '0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                opa   <= a;
                opb   <= op ? ~b : b;
                carry <= op ? ~cin : cin;
                idx   <= '0;
            end else if (step) begin
                opa    <= opa >> CHUNK;
                opb    <= opb >> CHUNK;
                carry  <= chunk_sum[CHUNK];
                shadow <= shifted[WIDTH+CHUNK-1:CHUNK];
                idx    <= idx + 1'b1;
            end
            if (last) begin
                sum  <= shifted[WIDTH+CHUNK-1:CHUNK];
                cout <= chunk_sum[CHUNK];
                ovf  <= chunk_ovf;
            end
        end
endmodule

// File: tb/tb_seq_addsub_chunked.sv
// tb_seq_addsub_chunked: scoreboard bench for seq_addsub_chunked at CHUNK=4, 16 and 1
module tb_seq_addsub_chunked;
    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    logic clk = 0, rst_n = 0, start = 0, op = 0, cin = 0;
    logic [15:0] a = 0, b = 0;
    logic busy4, done4, cout4, ovf4, busy16, done16, cout16, ovf16, busy1, done1, cout1, ovf1;
    logic [15:0] sum4, sum16, sum1;
    exp_t q[$];
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    seq_addsub_chunked #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cin(cin), .a(a), .b(b),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));
    seq_addsub_chunked #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cin(cin), .a(a), .b(b),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16));
    seq_addsub_chunked #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cin(cin), .a(a), .b(b),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

    function automatic exp_t model(input logic o, input logic c, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] full;
        exp_t e;
        full = o ? {1'b0, x} - {1'b0, y} - 17'(c) : {1'b0, x} + {1'b0, y} + 17'(c);
        e.s = full[15:0];
        e.co = o ? ~full[16] : full[16];
        e.ov = o ? (x[15] != y[15]) && (e.s[15] != x[15]) : (x[15] == y[15]) && (e.s[15] != x[15]);
        return e;
    endfunction

    // Drive one request and leave the bench #1 after the accepting edge.
    task automatic issue(input logic o, input logic c, input logic [15:0] x, input logic [15:0] y);
        op = o; cin = c; a = x; b = y; start = 1;
        q.push_back(model(o, c, x, y));
        @(posedge clk); #1;
        start = 0;
    endtask

    // Wait for the selected instance's done pulse; lat counts edges, maxc+1 on timeout.
    task automatic collect(input int sel, input int maxc, output int lat, output int busy_cyc);
        logic d;
        lat = 0; busy_cyc = 0;
        d = 0;
        while (!d && lat <= maxc) begin
            if (sel == 0 && busy4) busy_cyc++;
            @(posedge clk); #1;
            lat++;
            d = sel == 0 ? done4 : sel == 1 ? done16 : done1;
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        #12;
        n_chk++;
        if ({busy4, done4, sum4, cout4, ovf4} !== 19'd0) begin
            n_fail++; $display("FAIL reset_state got %h required 0", {busy4, done4, sum4, cout4, ovf4});
        end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_add;
        int lat, bc;
        exp_t e;
        issue(0, 0, 16'h1234, 16'h4321);
        collect(0, 20, lat, bc);
        e = q.pop_front();
        n_chk++;
        if (lat != 4) begin n_fail++; $display("FAIL add_latency got %0d required 4", lat); end
        n_chk++;
        if (bc != 4) begin n_fail++; $display("FAIL add_busy_cycles got %0d required 4", bc); end
        n_chk++;
        if ({sum4, cout4, ovf4} !== e) begin n_fail++; $display("FAIL add_basic got %h required %h", {sum4, cout4, ovf4}, e); end
        n_chk++;
        if (busy4 !== 1'b0) begin n_fail++; $display("FAIL busy_in_done got %b required 0", busy4); end
        @(posedge clk); #1;
        n_chk++;
        if (done4 !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got %b required 0", done4); end
    endtask

    task automatic test_boundary;
        int lat, bc;
        exp_t e;
        logic [33:0] v[4] = '{{1'b0, 1'b0, 16'hFFFF, 16'h0001}, {1'b0, 1'b0, 16'h7FFF, 16'h0001},
                              {1'b1, 1'b0, 16'h0005, 16'h0007}, {1'b1, 1'b0, 16'h8000, 16'h0001}};
        for (int i = 0; i < 4; i++) begin
            issue(v[i][33], v[i][32], v[i][31:16], v[i][15:0]);
            collect(0, 20, lat, bc);
            e = q.pop_front();
            n_chk++;
            if ({sum4, cout4, ovf4} !== e || lat != 4) begin
                n_fail++; $display("FAIL boundary_%0d got %h lat %0d required %h lat 4", i, {sum4, cout4, ovf4}, lat, e);
            end
        end
    endtask

    task automatic test_ignore_busy;
        int lat, bc;
        exp_t e, held;
        held = {sum4, cout4, ovf4};
        issue(0, 1, 16'h0F0F, 16'h1010);
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({sum4, cout4, ovf4} !== held) begin n_fail++; $display("FAIL hold_mid_run got %h required %h", {sum4, cout4, ovf4}, held); end
        op = 1; cin = 0; a = 16'hAAAA; b = 16'h5555; start = 1;
        @(posedge clk); #1;
        start = 0; a = 16'h0; b = 16'hFFFF;
        collect(0, 20, lat, bc);
        e = q.pop_front();
        n_chk++;
        if ({sum4, cout4, ovf4} !== e || lat != 1) begin
            n_fail++; $display("FAIL start_while_busy got %h lat %0d required %h lat 1", {sum4, cout4, ovf4}, lat, e);
        end
        repeat (6) @(posedge clk);
        #1;
        n_chk++;
        if (busy4 !== 1'b0) begin n_fail++; $display("FAIL no_queued_op got busy %b required 0", busy4); end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        exp_t e;
        issue(0, 0, 16'h1111, 16'h2222);
        collect(0, 20, lat, bc);
        e = q.pop_front();
        n_chk++;
        if ({sum4, cout4, ovf4} !== e) begin n_fail++; $display("FAIL b2b_first got %h required %h", {sum4, cout4, ovf4}, e); end
        issue(1, 1, 16'h3000, 16'h4001);
        collect(0, 20, lat, bc);
        e = q.pop_front();
        n_chk++;
        if ({sum4, cout4, ovf4} !== e || lat != 4) begin
            n_fail++; $display("FAIL b2b_second got %h lat %0d required %h lat 4", {sum4, cout4, ovf4}, lat, e);
        end
    endtask

    task automatic test_mid_reset;
        int lat, bc;
        exp_t e;
        issue(0, 0, 16'h0101, 16'h0202);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        void'(q.pop_front());
        n_chk++;
        if ({busy4, done4, sum4, cout4, ovf4} !== 19'd0) begin
            n_fail++; $display("FAIL mid_reset got %h required 0", {busy4, done4, sum4, cout4, ovf4});
        end
        @(posedge clk); #1;
        rst_n = 1;
        bc = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done4 || busy4) bc++;
        end
        n_chk++;
        if (bc != 0) begin n_fail++; $display("FAIL no_done_after_reset got %0d activity cycles required 0", bc); end
        issue(0, 0, 16'h8001, 16'h8001);
        collect(0, 20, lat, bc);
        e = q.pop_front();
        n_chk++;
        if ({sum4, cout4, ovf4} !== e || lat != 4) begin
            n_fail++; $display("FAIL after_reset got %h lat %0d required %h lat 4", {sum4, cout4, ovf4}, lat, e);
        end
    endtask

    task automatic test_random;
        int lat, bc;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            issue(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            collect(0, 20, lat, bc);
            e = q.pop_front();
            n_chk++;
            if ({sum4, cout4, ovf4} !== e) begin n_fail++; $display("FAIL random_%0d got %h required %h", i, {sum4, cout4, ovf4}, e); end
        end
    endtask

    task automatic test_chunk_sizes;
        int lat, bc;
        exp_t e;
        repeat (20) @(posedge clk);
        #1;
        issue(0, 1, 16'hABCD, 16'h1111);
        collect(1, 40, lat, bc);
        e = q[0];
        n_chk++;
        if ({sum16, cout16, ovf16} !== e || sum16 !== 16'hBCDF || lat != 1) begin
            n_fail++; $display("FAIL chunk16 got %h lat %0d required %h lat 1", {sum16, cout16, ovf16}, lat, e);
        end
        collect(2, 40, bc, lat);
        lat = bc + 1;
        e = q.pop_front();
        n_chk++;
        if ({sum1, cout1, ovf1} !== e || lat != 16) begin
            n_fail++; $display("FAIL chunk1 got %h lat %0d required %h lat 16", {sum1, cout1, ovf1}, lat, e);
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_boundary;
        test_ignore_busy;
        test_back_to_back;
        test_mid_reset;
        test_random;
        test_chunk_sizes;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
